// File: rtl/datapath_sequencer.sv
// Instruction sequencer for a two-ALU register-file datapath.
// Accepts one instruction at a time in IDLE and drives registered control outputs.
module datapath_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [19:0]      instr_in,
    output logic             IE,
    output logic [3:0]       WAA,
    output logic [3:0]       WAB,
    output logic [3:0]       RAA,
    output logic [3:0]       RAB,
    output logic             WEA,
    output logic             WEB,
    output logic             REA,
    output logic             REB,
    output logic [3:0]       S_ALU1,
    output logic [3:0]       S_ALU2,
    output logic             OE,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned INSTR_W = 20;
    localparam int unsigned FLD_W   = 4;

    localparam logic [FLD_W-1:0] OP_NOP  = 4'd0;
    localparam logic [FLD_W-1:0] OP_LOAD = 4'd1;
    localparam logic [FLD_W-1:0] OP_ALU1 = 4'd2;
    localparam logic [FLD_W-1:0] OP_ALU2 = 4'd3;
    localparam logic [FLD_W-1:0] OP_OUT  = 4'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 instr_ready_q, instr_ready_d;
    logic                 ie_q, ie_d;
    logic [FLD_W-1:0]     waa_q, waa_d;
    logic [FLD_W-1:0]     wab_q, wab_d;
    logic [FLD_W-1:0]     raa_q, raa_d;
    logic [FLD_W-1:0]     rab_q, rab_d;
    logic                 wea_q, wea_d;
    logic                 web_q, web_d;
    logic                 rea_q, rea_d;
    logic                 reb_q, reb_d;
    logic [FLD_W-1:0]     s_alu1_q, s_alu1_d;
    logic [FLD_W-1:0]     s_alu2_q, s_alu2_d;
    logic                 oe_q, oe_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     retired_q, retired_d;

    logic                 hs;
    logic [FLD_W-1:0]     op, func, rd, rs1, rs2;

    // State and registered outputs; reset has priority over any handshake
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            instr_ready_q <= 1'b0;
            ie_q          <= 1'b0;
            waa_q         <= '0;
            wab_q         <= '0;
            raa_q         <= '0;
            rab_q         <= '0;
            wea_q         <= 1'b0;
            web_q         <= 1'b0;
            rea_q         <= 1'b0;
            reb_q         <= 1'b0;
            s_alu1_q      <= '0;
            s_alu2_q      <= '0;
            oe_q          <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_ready_q <= instr_ready_d;
            ie_q          <= ie_d;
            waa_q         <= waa_d;
            wab_q         <= wab_d;
            raa_q         <= raa_d;
            rab_q         <= rab_d;
            wea_q         <= wea_d;
            web_q         <= web_d;
            rea_q         <= rea_d;
            reb_q         <= reb_d;
            s_alu1_q      <= s_alu1_d;
            s_alu2_q      <= s_alu2_d;
            oe_q          <= oe_d;
            done_q        <= done_d;
            err_q         <= err_d;
            retired_q     <= retired_d;
        end
    end

    // Next state, then outputs decoded from the state being entered
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_ready_d = 1'b0;
        ie_d          = 1'b0;
        waa_d         = waa_q;
        wab_d         = wab_q;
        raa_d         = raa_q;
        rab_d         = rab_q;
        wea_d         = 1'b0;
        web_d         = 1'b0;
        rea_d         = 1'b0;
        reb_d         = 1'b0;
        s_alu1_d      = s_alu1_q;
        s_alu2_d      = s_alu2_q;
        oe_d          = 1'b0;
        done_d        = 1'b0;
        err_d         = err_q;
        retired_d     = retired_q;

        hs = instr_ready_q & instr_valid;
        if (hs) begin
            instr_d = instr_in;
        end
        op   = instr_d[19:16];
        func = instr_d[15:12];
        rd   = instr_d[11:8];
        rs1  = instr_d[7:4];
        rs2  = instr_d[3:0];

        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    unique case (op)
                        OP_NOP:                  state_d = DONE;
                        OP_LOAD:                 state_d = WRITE;
                        OP_ALU1, OP_ALU2, OP_OUT: state_d = READ;
                        default: begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            IDLE: instr_ready_d = 1'b1;
            READ: begin
                rea_d = 1'b1;
                reb_d = 1'b1;
                raa_d = rs1;
                rab_d = rs2;
                if (op == OP_ALU1) begin
                    s_alu1_d = func;
                end
                if (op == OP_ALU2) begin
                    s_alu2_d = func;
                end
            end
            EXEC: begin
                rea_d = 1'b1;
                reb_d = 1'b1;
            end
            WRITE: begin
                unique case (op)
                    OP_LOAD: begin
                        ie_d  = 1'b1;
                        wab_d = rd;
                        web_d = 1'b1;
                    end
                    OP_ALU1: begin
                        waa_d = rd;
                        wea_d = 1'b1;
                        rea_d = 1'b1;
                        reb_d = 1'b1;
                    end
                    OP_ALU2: begin
                        wab_d = rd;
                        web_d = 1'b1;
                        rea_d = 1'b1;
                        reb_d = 1'b1;
                    end
                    OP_OUT:  oe_d = 1'b1;
                    default: ;
                endcase
            end
            DONE: begin
                done_d    = 1'b1;
                retired_d = retired_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    assign instr_ready = instr_ready_q;
    assign IE          = ie_q;
    assign WAA         = waa_q;
    assign WAB         = wab_q;
    assign RAA         = raa_q;
    assign RAB         = rab_q;
    assign WEA         = wea_q;
    assign WEB         = web_q;
    assign REA         = rea_q;
    assign REB         = reb_q;
    assign S_ALU1      = s_alu1_q;
    assign S_ALU2      = s_alu2_q;
    assign OE          = oe_q;
    assign done        = done_q;
    assign err         = err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: per-cycle timeline model plus literal spot checks.
module tb_datapath_sequencer;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned VW    = 34 + CNT_W;

    logic             CLK;
    logic             RST;
    logic             instr_valid;
    logic             instr_ready;
    logic [19:0]      instr_in;
    logic             IE;
    logic [3:0]       WAA, WAB, RAA, RAB;
    logic             WEA, WEB, REA, REB;
    logic [3:0]       S_ALU1, S_ALU2;
    logic             OE, done, err;
    logic [CNT_W-1:0] retired;

    datapath_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_in(instr_in), .IE(IE), .WAA(WAA), .WAB(WAB), .RAA(RAA), .RAB(RAB),
        .WEA(WEA), .WEB(WEB), .REA(REA), .REB(REB), .S_ALU1(S_ALU1), .S_ALU2(S_ALU2),
        .OE(OE), .done(done), .err(err), .retired(retired)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk = 0;
    int n_err = 0;

    // DUT-side observations
    int cyc = 0;
    int hs_n = 0, hs_prev = 0, hs_last = 0;
    int wea_n = 0, web_n = 0, webie0_n = 0, oe_n = 0, done_n = 0;

    // Model state: position inside the current instruction's timeline
    logic             m_live = 1'b0;
    logic             m_busy = 1'b0, m_rdy = 1'b0, m_err = 1'b0;
    int               m_k = 0, m_lat = 0;
    logic [19:0]      m_ins = '0;
    logic [3:0]       m_op;
    logic [3:0]       m_waa = '0, m_wab = '0, m_raa = '0, m_rab = '0, m_s1 = '0, m_s2 = '0;
    logic [CNT_W-1:0] m_ret = '0;
    logic             e_ie, e_wea, e_web, e_re, e_oe, e_done;
    logic [VW-1:0]    exp_v, act_v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'd1) return 2;
        if (op >= 4'd2 && op <= 4'd4) return 4;
        return 1;
    endfunction

    task automatic issue(input logic [19:0] ins);
        int w;
        w = 0;
        while (instr_ready !== 1'b1 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        if (instr_ready !== 1'b1) chk("ready_timeout", 64'(instr_ready), 64'd1);
        instr_valid = 1'b1;
        instr_in    = ins;
        @(negedge CLK);
        instr_valid = 1'b0;
        instr_in    = 20'($urandom);
    endtask

    initial begin
        logic [1:0] exp_ret [5];
        int h0, o0, w0, wi0, a0, d0, w;

        RST = 1'b1;
        instr_valid = 1'b0;
        instr_in = '0;

        fork
            // Timeline model and per-cycle compare
            forever begin
                @(posedge CLK);
                if (RST) begin
                    m_live = 1'b1; m_busy = 1'b0; m_rdy = 1'b0; m_err = 1'b0; m_ret = '0;
                    m_waa = '0; m_wab = '0; m_raa = '0; m_rab = '0; m_s1 = '0; m_s2 = '0;
                end else begin
                    if (m_busy) begin
                        m_k++;
                        if (m_k > m_lat) m_busy = 1'b0;
                    end else if (m_rdy && instr_valid) begin
                        m_busy = 1'b1;
                        m_k    = 1;
                        m_ins  = instr_in;
                        m_lat  = lat_of(instr_in[19:16]);
                        if (instr_in[19:16] > 4'd4) m_err = 1'b1;
                    end
                    m_rdy = !m_busy;
                end
                e_ie = 0; e_wea = 0; e_web = 0; e_re = 0; e_oe = 0; e_done = 0;
                m_op = m_ins[19:16];
                if (m_busy) begin
                    if (m_k == m_lat) begin
                        e_done = 1'b1;
                        m_ret  = m_ret + CNT_W'(1);
                    end
                    if (m_lat == 4) begin
                        if (m_k == 1) begin
                            m_raa = m_ins[7:4];
                            m_rab = m_ins[3:0];
                            if (m_op == 4'd2) m_s1 = m_ins[15:12];
                            if (m_op == 4'd3) m_s2 = m_ins[15:12];
                        end
                        e_re = (m_k <= 2) || (m_k == 3 && (m_op == 4'd2 || m_op == 4'd3));
                        if (m_k == 3) begin
                            if (m_op == 4'd2) begin e_wea = 1'b1; m_waa = m_ins[11:8]; end
                            if (m_op == 4'd3) begin e_web = 1'b1; m_wab = m_ins[11:8]; end
                            if (m_op == 4'd4) e_oe = 1'b1;
                        end
                    end else if (m_op == 4'd1 && m_k == 1) begin
                        e_ie = 1'b1; e_web = 1'b1; m_wab = m_ins[11:8];
                    end
                end
                #1;
                if (m_live) begin
                    exp_v = {m_rdy, e_ie, m_waa, m_wab, m_raa, m_rab, e_wea, e_web, e_re, e_re,
                             m_s1, m_s2, e_oe, e_done, m_err, m_ret};
                    act_v = {instr_ready, IE, WAA, WAB, RAA, RAB, WEA, WEB, REA, REB,
                             S_ALU1, S_ALU2, OE, done, err, retired};
                    chk("cycle_outputs", 64'(act_v), 64'(exp_v));
                end
            end
            // Handshake monitor
            forever begin
                @(posedge CLK);
                cyc++;
                if (!RST && instr_valid && instr_ready) begin
                    hs_n++;
                    hs_prev = hs_last;
                    hs_last = cyc;
                end
            end
            // Pulse counters
            forever begin
                @(negedge CLK);
                if (WEA) wea_n++;
                if (WEB) web_n++;
                if (WEB && !IE) webie0_n++;
                if (OE) oe_n++;
                if (done) done_n++;
            end
        join_none

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ready", 64'(instr_ready), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_ctrl", 64'({WEA, WEB, REA, REB, OE, done, err, IE, WAA, WAB, RAA, RAB, S_ALU1, S_ALU2}), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", 64'(instr_ready), 64'd1);

        // Reset wins over a handshake on the same edge
        RST = 1'b1; instr_valid = 1'b1; instr_in = 20'h00000;
        @(negedge CLK);
        chk("rst_prio_ready", 64'(instr_ready), 64'd0);
        chk("rst_prio_done", 64'(done), 64'd0);
        RST = 1'b0; instr_valid = 1'b0;
        @(negedge CLK);
        chk("rst_prio_ready2", 64'(instr_ready), 64'd1);

        // LOAD rd=5
        issue(20'h10500);
        chk("load_write", 64'({WEB, WAB, IE, done}), 64'({1'b1, 4'd5, 1'b1, 1'b0}));
        @(negedge CLK);
        chk("load_done", 64'({done, retired}), 64'({1'b1, 2'd1}));

        // ALU1 func=3 rd=2 rs1=1 rs2=4
        issue(20'h23214);
        for (int k = 1; k <= 3; k++) begin
            chk("alu1_read", 64'({REA, REB, RAA, RAB, S_ALU1}), 64'({1'b1, 1'b1, 4'd1, 4'd4, 4'd3}));
            chk("alu1_wea", 64'(WEA), 64'(k == 3));
            @(negedge CLK);
        end
        chk("alu1_waa", 64'(WAA), 64'd2);
        chk("alu1_done", 64'({done, WEA, retired}), 64'({1'b1, 1'b0, 2'd2}));

        // OUT then ALU2 with instr_valid held
        @(negedge CLK);
        h0 = hs_n; o0 = oe_n; w0 = web_n; wi0 = webie0_n;
        instr_valid = 1'b1; instr_in = 20'h40036;
        @(negedge CLK);
        instr_in = 20'h35789;
        w = 0;
        while (hs_n < h0 + 2 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        chk("b2b_hs_count", 64'(hs_n - h0), 64'd2);
        instr_valid = 1'b0;
        repeat (6) @(negedge CLK);
        chk("b2b_gap", 64'(hs_last - hs_prev), 64'd5);
        chk("b2b_oe_pulses", 64'(oe_n - o0), 64'd1);
        chk("b2b_web_pulses", 64'(web_n - w0), 64'd1);
        chk("b2b_web_ie0", 64'(webie0_n - wi0), 64'd1);
        chk("b2b_alu2_regs", 64'({S_ALU2, WAB, retired}), 64'({4'd5, 4'd7, 2'd0}));

        // Illegal opcode 7, then NOP
        issue(20'h7abcd);
        chk("ill_err_done", 64'({err, done}), 64'({1'b1, 1'b1}));
        chk("ill_no_en", 64'({WEA, WEB, REA, REB, OE, IE}), 64'd0);
        @(negedge CLK);
        issue(20'h00000);
        chk("nop_after_ill", 64'({done, err}), 64'({1'b1, 1'b1}));
        @(negedge CLK);
        chk("err_sticky", 64'(err), 64'd1);

        // Reset during EXEC of ALU1
        issue(20'h23214);
        @(negedge CLK);
        a0 = wea_n; d0 = done_n;
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_ready", 64'(instr_ready), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_ready_after", 64'(instr_ready), 64'd1);
        repeat (4) @(negedge CLK);
        chk("abort_no_wea", 64'(wea_n - a0), 64'd0);
        chk("abort_no_done", 64'(done_n - d0), 64'd0);
        chk("abort_err_clr", 64'({err, retired}), 64'd0);

        // Five NOPs with a 2-bit counter
        exp_ret = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            issue(20'h00000);
            chk("nop_retired", 64'({done, retired}), 64'({1'b1, exp_ret[i]}));
            @(negedge CLK);
        end

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter CNT_W, default 8: width of the retired-instruction counter.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 instr_valid  input  1  instr_in holds a valid instruction.
REQ-005 instr_ready  output  1  sequencer can accept an instruction (high only in IDLE).
REQ-006 instr_in  input  20  [19:16] op, [15:12] func, [11:8] rd, [7:4] rs1, [3:0] rs2.
REQ-007 IE  output  1  datapath input-mux select; 1 = DataIn, 0 = ALU2 result.
REQ-008 WAA, WAB, RAA, RAB  output  4 each  register-file write/read addresses.
REQ-009 WEA, WEB, REA, REB  output  1 each  register-file write/read enables.
REQ-010 S_ALU1, S_ALU2  output  4 each  ALU1/ALU2 function selects.
REQ-011 OE  output  1  output-register load enable.
REQ-012 done  output  1  one-cycle pulse when an instruction retires.
REQ-013 err  output  1  sticky illegal-opcode flag.
REQ-014 retired  output  CNT_W  count of retired instructions.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have the states IDLE, READ, EXEC, WRITE and DONE.
REQ-017 IDLE: instr_ready=1; a handshake occurs when instr_valid=1 and instr_ready=1 on the same edge; the instruction is latched.
REQ-018 After the handshake the FSM SHALL go to READ, except LOAD, which goes to WRITE.
REQ-019 A handshake with an illegal opcode SHALL set err, go to DONE and leave all enables low.
REQ-020 Opcodes: 0 NOP, 1 LOAD, 2 ALU1, 3 ALU2, 4 OUT; 5-15 are illegal.
REQ-021 NOP SHALL go IDLE->DONE with no enables asserted.
REQ-022 READ (1 cycle): REA=1 with RAA=rs1, REB=1 with RAB=rs2; S_ALU1 or S_ALU2 is set to func according to op.
REQ-023 EXEC (1 cycle): read enables, addresses and ALU selects held stable so the ALU results settle.
REQ-024 WRITE (1 cycle), by opcode:
- LOAD: IE=1, WAB=rd, WEB=1.
- ALU1: WAA=rd, WEA=1; read enables still held.
- ALU2: IE=0, WAB=rd, WEB=1; read enables still held.
- OUT: OE=1, no register-file write.
REQ-025 WEA, WEB and OE SHALL each be high for exactly one cycle per instruction, and only in WRITE.
REQ-026 DONE (1 cycle): done=1 and retired increments; the FSM returns to IDLE.
REQ-027 retired SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 Latency from handshake edge to done:
- LOAD: 2 cycles.
- NOP and illegal: 1 cycle.
- ALU1, ALU2 and OUT: 4 cycles.
REQ-029 Minimum spacing between handshakes SHALL be latency+1 cycles.
REQ-030 In every state other than those listed, all enables SHALL be 0; IE defaults to 0; addresses and selects hold their last value.
REQ-031 instr_valid while not in IDLE SHALL be ignored and not queued; instr_in changes after the handshake SHALL have no effect.
REQ-032 An illegal instruction SHALL count as retired; err stays set until RST.

Reset
REQ-033 RST=1 at a clock edge SHALL force IDLE and clear all enables, IE, done, err and retired to 0, and all addresses and selects to 0.
REQ-034 RST SHALL take priority over a handshake on the same edge.
REQ-035 RST mid-instruction SHALL abort the instruction with no further write enable and no done pulse.
REQ-036 instr_ready SHALL be 0 while RST=1 and 1 on the first cycle after RST deasserts.

Verification
REQ-037 LOAD rd=5 (0x1_0_5_0_0) handshake at cycle 0 -> WEB=1, WAB=5, IE=1 at cycle 1; done at cycle 2; retired=1.
REQ-038 ALU1 func=3, rd=2, rs1=1, rs2=4 -> REA/REB high in cycles 1-3 with RAA=1, RAB=4, S_ALU1=3; WEA=1, WAA=2 only in cycle 3; done at cycle 4.
REQ-039 OUT then ALU2 back-to-back with instr_valid held high -> second handshake exactly 5 cycles after the first; OE pulses once; WEB pulses once with IE=0.
REQ-040 Opcode 0x7 -> err=1, no enables, done after 1 cycle; err remains 1 after a following NOP.
REQ-041 RST asserted during EXEC of an ALU1 -> no WEA pulse, no done; IDLE with instr_ready=1 the cycle after RST drops.
REQ-042 With CNT_W=2, five NOPs -> retired reads 1,2,3,0,1.
